// File: rtl/bits_sched_pkg.sv
// Shared constants and the response tag type for the bits_sched scheduler.
package bits_sched_pkg;

  localparam int WORD_W     = 32;
  localparam int BUF_BITS   = 1024;
  localparam int LEN_W      = 4;
  localparam int DATA_W     = 15;
  localparam int LVL_W      = 11;
  localparam int PUSH_LIMIT = BUF_BITS - WORD_W;

  // Wide enough for the largest supported requester count (8).
  localparam int ID_MAX_W   = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/bits_sched_if.sv
// Upstream, requester and bits-buffer signals of bits_sched.
// The slave modport is the scheduler view; master is the surrounding environment.
interface bits_sched_if
  import bits_sched_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic                    up_valid;
  logic [WORD_W-1:0]       up_data;
  logic                    up_ready;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*LEN_W-1:0]   req_len;
  logic [NREQ-1:0]         req_ready;
  logic                    bits_pushin;
  logic [WORD_W-1:0]       bits_datain;
  logic                    bits_reqin;
  logic [LEN_W-1:0]        bits_reqlen;
  logic                    bits_pushout;
  logic [LEN_W-1:0]        bits_lenout;
  logic [DATA_W-1:0]       bits_dataout;
  logic [NREQ-1:0]         rsp_valid;
  logic [LEN_W-1:0]        rsp_len;
  logic [DATA_W-1:0]       rsp_data;
  logic [LVL_W-1:0]        level;
  logic                    err;

  modport master (
    output up_valid, up_data, req_valid, req_len,
           bits_pushout, bits_lenout, bits_dataout,
    input  up_ready, req_ready, bits_pushin, bits_datain, bits_reqin,
           bits_reqlen, rsp_valid, rsp_len, rsp_data, level, err
  );

  modport slave (
    input  up_valid, up_data, req_valid, req_len,
           bits_pushout, bits_lenout, bits_dataout,
    output up_ready, req_ready, bits_pushin, bits_datain, bits_reqin,
           bits_reqlen, rsp_valid, rsp_len, rsp_data, level, err
  );

endinterface

// File: rtl/bits_sched_rr.sv
// Round-robin picker: first set request searching upward from last+1 with wrap.
module bits_sched_rr #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   pick_oh,
  output logic [IDW-1:0] pick_idx,
  output logic           pick_any
);

  logic [IDW-1:0] slot;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    slot     = '0;
    for (int k = 1; k <= N; k++) begin
      slot = IDW'((int'(last) + k) % N);
      if (!pick_any && req[slot]) begin
        pick_any = 1'b1;
        pick_idx = slot;
        pick_oh  = N'(1) << slot;
      end
    end
  end

endmodule

// File: rtl/bits_sched.sv
// Meters upstream words into the 1024-bit bits buffer and round-robins requesters onto it.
// BITS_SCHED_PRIO_EN: requester 0 becomes fixed-highest priority.
module bits_sched
  import bits_sched_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic        clk,
  input  logic        rst,
  bits_sched_if.slave bus
);

  logic [LVL_W-1:0] level_q, level_d;
  logic [IDW-1:0]   last_q;
  tag_t             tag1_q, tag2_q;
  logic             err_q;

  logic             up_ready, push, grant, prio_hit;
  logic [NREQ-1:0]  rr_req, rr_oh, cand_oh;
  logic [IDW-1:0]   rr_idx, cand_idx;
  logic             rr_any, cand_any;
  logic [LEN_W-1:0] cand_len;

`ifdef BITS_SCHED_PRIO_EN
  assign prio_hit = bus.req_valid[0];
  assign rr_req   = bus.req_valid & ~NREQ'(1);
`else
  assign prio_hit = 1'b0;
  assign rr_req   = bus.req_valid;
`endif

  bits_sched_rr #(.N(NREQ), .IDW(IDW)) u_rr (
    .req      (rr_req),
    .last     (last_q),
    .pick_oh  (rr_oh),
    .pick_idx (rr_idx),
    .pick_any (rr_any)
  );

  assign cand_oh  = prio_hit ? NREQ'(1) : rr_oh;
  assign cand_idx = prio_hit ? '0 : rr_idx;
  assign cand_any = prio_hit | rr_any;
  assign cand_len = bus.req_len[int'(cand_idx)*LEN_W +: LEN_W];

  // The buffer serves requests from its pre-edge contents, so only the registered level counts.
  assign grant    = cand_any && (LVL_W'(cand_len) <= level_q);
  assign up_ready = (level_q <= LVL_W'(PUSH_LIMIT));
  assign push     = bus.up_valid & up_ready;

  always_comb begin
    level_d = level_q;
    if (push)  level_d = level_d + LVL_W'(WORD_W);
    if (grant) level_d = level_d - LVL_W'(cand_len);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      tag1_q  <= '0;
      tag2_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q      <= level_d;
      if (grant && !prio_hit) last_q <= cand_idx;
      tag1_q.valid <= grant;
      tag1_q.id    <= ID_MAX_W'(cand_idx);
      tag2_q       <= tag1_q;
      if (tag2_q.valid != bus.bits_pushout) err_q <= 1'b1;
    end
  end

  assign bus.up_ready    = up_ready;
  assign bus.bits_pushin = push;
  assign bus.bits_datain = bus.up_data;
  assign bus.req_ready   = grant ? cand_oh : '0;
  assign bus.bits_reqin  = grant;
  assign bus.bits_reqlen = grant ? cand_len : '0;
  assign bus.rsp_valid   = (tag2_q.valid && bus.bits_pushout) ? (NREQ'(1) << tag2_q.id) : '0;
  assign bus.rsp_len     = bus.bits_lenout;
  assign bus.rsp_data    = bus.bits_dataout;
  assign bus.level       = level_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_bits_sched.sv
// Bench for bits_sched: a bits-buffer stand-in plus a queue-based reference model of the scheduler.
module tb_bits_sched;
  import bits_sched_pkg::*;

  localparam int NREQ = 4;
`ifdef BITS_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bits_sched_if #(.NREQ(NREQ)) bus ();
  bits_sched #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Stand-in for the bits buffer: two-cycle read latency, LSB-first bit stream.
  bit          bq[$];
  bit          s1_v = 1'b0, s2_v = 1'b0, inj = 1'b0;
  logic [3:0]  s1_len = '0, s2_len = '0;
  logic [14:0] s1_d = '0, s2_d = '0;
  assign bus.bits_pushout = s2_v | inj;
  assign bus.bits_lenout  = s2_v ? s2_len : 4'd0;
  assign bus.bits_dataout = s2_v ? s2_d : 15'd0;

  // Reference model state.
  int          m_level, m_last;
  bit          m_err;
  bit          ref_q[$];
  bit          p1_v, p2_v;
  int          p1_id, p2_id;
  logic [3:0]  p1_len, p2_len;
  logic [14:0] p1_d, p2_d;
  bit          e_grant, e_push, e_up_ready;
  int          e_id;
  logic [3:0]  e_len;
  logic [3:0]  e_rdy;

  task automatic settle();
    bit found;
    int cid;
    #1;
    found = 0; cid = 0; e_grant = 0; e_id = 0; e_len = '0;
    if (PRIO && bus.req_valid[0]) begin
      found = 1; cid = 0;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int j = (m_last + k) % NREQ;
        if (!found && bus.req_valid[j] && !(PRIO && j == 0)) begin
          found = 1; cid = j;
        end
      end
    end
    if (found && int'(bus.req_len[4*cid +: 4]) <= m_level) begin
      e_grant = 1; e_id = cid; e_len = bus.req_len[4*cid +: 4];
    end
    e_up_ready = (m_level <= PUSH_LIMIT);
    e_push     = bus.up_valid && e_up_ready;
    e_rdy      = e_grant ? 4'(1 << e_id) : 4'd0;
  endtask

  task automatic advance();
    bit          rq, pi;
    logic [3:0]  rl;
    logic [31:0] pd;
    logic [14:0] d;
    rq = bus.bits_reqin; rl = bus.bits_reqlen; pi = bus.bits_pushin; pd = bus.bits_datain;
    @(posedge clk);
    #1;
    d = '0;
    if (rq) for (int k = 0; k < int'(rl); k++) if (bq.size() > 0) d = d | (15'(bq.pop_front()) << k);
    s2_v = s1_v; s2_len = s1_len; s2_d = s1_d;
    s1_v = rq; s1_len = rl; s1_d = d;
    if (pi) for (int k = 0; k < 32; k++) begin bq.push_back(pd[0]); pd = pd >> 1; end
    if (inj && !p2_v) m_err = 1;
    d = '0;
    if (e_grant) for (int k = 0; k < int'(e_len); k++) if (ref_q.size() > 0) d = d | (15'(ref_q.pop_front()) << k);
    p2_v = p1_v; p2_id = p1_id; p2_len = p1_len; p2_d = p1_d;
    p1_v = e_grant; p1_id = e_id; p1_len = e_grant ? e_len : 4'd0; p1_d = d;
    if (e_push) begin
      pd = bus.up_data;
      for (int k = 0; k < 32; k++) begin ref_q.push_back(pd[0]); pd = pd >> 1; end
    end
    m_level = m_level + (e_push ? 32 : 0) - (e_grant ? int'(e_len) : 0);
    if (e_grant && !(PRIO && e_id == 0)) m_last = e_id;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    bus.up_valid = 1'b0; bus.up_data = '0; bus.req_valid = '0; bus.req_len = '0;
    inj = 0; bq.delete(); ref_q.delete();
    s1_v = 0; s2_v = 0; s1_len = '0; s2_len = '0; s1_d = '0; s2_d = '0;
    m_level = 0; m_last = NREQ - 1; m_err = 0;
    p1_v = 0; p2_v = 0; p1_id = 0; p2_id = 0; p1_len = '0; p2_len = '0; p1_d = '0; p2_d = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if ({bus.up_ready, bus.bits_pushin, bus.req_ready, bus.bits_reqin, bus.bits_reqlen} !== {1'b1, 1'b0, 4'b0, 1'b0, 4'b0}) begin
      errors++; $display("FAIL reset_ctrl got %b want %b", {bus.up_ready, bus.bits_pushin, bus.req_ready, bus.bits_reqin, bus.bits_reqlen}, 11'b10000000000);
    end
    checks++;
    if ({bus.rsp_valid, bus.level, bus.err} !== 16'd0) begin
      errors++; $display("FAIL reset_state got rsp=%b level=%0d err=%b want 0", bus.rsp_valid, bus.level, bus.err);
    end
    bus.up_valid = 1'b1; bus.up_data = $urandom;
    settle();
    advance();
    bus.up_valid = 1'b0;
    settle();
    checks++;
    if (bus.level !== 11'd32) begin errors++; $display("FAIL reset_push got %0d want 32", bus.level); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.level !== 11'd0) begin errors++; $display("FAIL reset_async got %0d want 0", bus.level); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [31:0] w[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      bus.up_valid = 1'b1; bus.up_data = w[i];
      settle();
      checks++;
      if (bus.bits_pushin !== 1'b1) begin errors++; $display("FAIL basic_push got %b want 1", bus.bits_pushin); end
      advance();
    end
    bus.up_valid = 1'b0; bus.req_valid = 4'b0010; bus.req_len = 16'h00F0;
    settle();
    checks++;
    if ({bus.level, bus.req_ready, bus.bits_reqin, bus.bits_reqlen} !== {11'd96, 4'b0010, 1'b1, 4'd15}) begin
      errors++; $display("FAIL basic_grant got level=%0d rdy=%b reqin=%b len=%0d want 96 0010 1 15", bus.level, bus.req_ready, bus.bits_reqin, bus.bits_reqlen);
    end
    advance();
    bus.req_valid = '0;
    settle();
    checks++;
    if ({bus.level, bus.rsp_valid} !== {11'd81, 4'b0000}) begin
      errors++; $display("FAIL basic_level got level=%0d rsp=%b want 81 0000", bus.level, bus.rsp_valid);
    end
    advance();
    settle();
    checks++;
    if ({bus.rsp_valid, bus.rsp_len, bus.rsp_data} !== {4'b0010, 4'd15, w[0][14:0]}) begin
      errors++; $display("FAIL basic_rsp got %b/%0d/%h want 0010/15/%h", bus.rsp_valid, bus.rsp_len, bus.rsp_data, w[0][14:0]);
    end
    advance();
  endtask

  task automatic test_push_same_cycle();
    do_reset();
    bus.up_valid = 1'b1; bus.up_data = $urandom; bus.req_valid = 4'b0001; bus.req_len = 16'h0008;
    settle();
    checks++;
    if ({bus.req_ready, bus.bits_pushin} !== {4'b0000, 1'b1}) begin
      errors++; $display("FAIL same_cycle_nogrant got rdy=%b push=%b want 0000 1", bus.req_ready, bus.bits_pushin);
    end
    advance();
    bus.up_valid = 1'b0;
    settle();
    checks++;
    if ({bus.level, bus.req_ready} !== {11'd32, 4'b0001}) begin
      errors++; $display("FAIL same_cycle_grant got level=%0d rdy=%b want 32 0001", bus.level, bus.req_ready);
    end
    advance();
    bus.req_valid = '0;
    settle();
    checks++;
    if (bus.level !== 11'd24) begin errors++; $display("FAIL same_cycle_level got %0d want 24", bus.level); end
    advance();
  endtask

  task automatic test_len_zero();
    do_reset();
    bus.req_valid = 4'b1000; bus.req_len = 16'h0000;
    settle();
    checks++;
    if ({bus.req_ready, bus.bits_reqin, bus.bits_reqlen} !== {4'b1000, 1'b1, 4'd0}) begin
      errors++; $display("FAIL len0_grant got rdy=%b reqin=%b len=%0d want 1000 1 0", bus.req_ready, bus.bits_reqin, bus.bits_reqlen);
    end
    advance();
    bus.req_valid = '0;
    settle();
    advance();
    settle();
    checks++;
    if ({bus.rsp_valid, bus.rsp_len, bus.rsp_data, bus.level} !== {4'b1000, 4'd0, 15'd0, 11'd0}) begin
      errors++; $display("FAIL len0_rsp got %b/%0d/%h level=%0d want 1000/0/0 level 0", bus.rsp_valid, bus.rsp_len, bus.rsp_data, bus.level);
    end
    advance();
  endtask

  task automatic test_fill();
    do_reset();
    bus.up_valid = 1'b1;
    for (int i = 0; i < 31; i++) begin bus.up_data = $urandom; settle(); advance(); end
    bus.up_data = $urandom;
    settle();
    checks++;
    if ({bus.level, bus.up_ready} !== {11'd992, 1'b1}) begin
      errors++; $display("FAIL fill_992 got level=%0d ready=%b want 992 1", bus.level, bus.up_ready);
    end
    advance();
    bus.req_valid = 4'b0001; bus.req_len = 16'h000F;
    settle();
    checks++;
    if ({bus.level, bus.up_ready, bus.bits_pushin, bus.req_ready} !== {11'd1024, 1'b0, 1'b0, 4'b0001}) begin
      errors++; $display("FAIL fill_full got level=%0d ready=%b push=%b rdy=%b want 1024 0 0 0001", bus.level, bus.up_ready, bus.bits_pushin, bus.req_ready);
    end
    advance();
    bus.req_len = 16'h0002;
    settle();
    checks++;
    if ({bus.level, bus.up_ready} !== {11'd1009, 1'b0}) begin
      errors++; $display("FAIL fill_1009 got level=%0d ready=%b want 1009 0", bus.level, bus.up_ready);
    end
    advance();
    bus.req_len = 16'h000F;
    settle();
    advance();
    bus.req_valid = '0;
    settle();
    checks++;
    if ({bus.level, bus.up_ready, bus.bits_pushin} !== {11'd992, 1'b1, 1'b1}) begin
      errors++; $display("FAIL fill_reopen got level=%0d ready=%b push=%b want 992 1 1", bus.level, bus.up_ready, bus.bits_pushin);
    end
    advance();
    bus.up_valid = 1'b0;
    repeat (3) begin settle(); advance(); end
  endtask

  task automatic test_rr();
    int want;
    do_reset();
    bus.up_valid = 1'b1;
    repeat (2) begin bus.up_data = $urandom; settle(); advance(); end
    bus.up_valid = 1'b0; bus.req_valid = 4'b1111; bus.req_len = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      want = PRIO ? 0 : (i % 4);
      settle();
      checks++;
      if (bus.req_ready !== 4'(1 << want)) begin
        errors++; $display("FAIL rr_order step %0d got %b want %b", i, bus.req_ready, 4'(1 << want));
      end
      advance();
    end
    bus.req_valid = '0;
    repeat (2) begin settle(); advance(); end
  endtask

  task automatic test_no_bypass();
    do_reset();
    bus.up_valid = 1'b1; bus.up_data = $urandom;
    settle(); advance();
    bus.up_valid = 1'b0; bus.req_valid = 4'b0010; bus.req_len = 16'h00F0;
    settle(); advance();
    bus.req_len = 16'h0070;
    settle(); advance();
    bus.req_valid = 4'b1100; bus.req_len = 16'h1F00;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({bus.level, bus.req_ready} !== {11'd10, 4'b0000}) begin
        errors++; $display("FAIL nobypass_hold got level=%0d rdy=%b want 10 0000", bus.level, bus.req_ready);
      end
      advance();
    end
    bus.up_valid = 1'b1; bus.up_data = $urandom;
    settle();
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL nobypass_push got %b want 0000", bus.req_ready); end
    advance();
    bus.up_valid = 1'b0;
    settle();
    checks++;
    if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL nobypass_two got %b want 0100", bus.req_ready); end
    advance();
    settle();
    checks++;
    if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL nobypass_three got %b want 1000", bus.req_ready); end
    advance();
    bus.req_valid = '0;
    repeat (2) begin settle(); advance(); end
  endtask

  task automatic test_err();
    do_reset();
    inj = 1;
    settle();
    checks++;
    if ({bus.err, bus.rsp_valid} !== 5'b0) begin errors++; $display("FAIL err_pre got err=%b rsp=%b want 0 0000", bus.err, bus.rsp_valid); end
    advance();
    inj = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky cycle %0d got %b want 1", i, bus.err); end
      advance();
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", bus.err); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.up_valid  = (i < 200) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      bus.up_data   = $urandom;
      bus.req_valid = 4'($urandom);
      bus.req_len   = 16'($urandom);
      settle();
      checks++;
      if ({bus.up_ready, bus.bits_pushin, bus.req_ready, bus.bits_reqin, bus.bits_reqlen} !==
          {e_up_ready, e_push, e_rdy, e_grant, (e_grant ? e_len : 4'd0)}) begin
        errors++; $display("FAIL rand_ctrl cycle %0d got %b want %b", i,
          {bus.up_ready, bus.bits_pushin, bus.req_ready, bus.bits_reqin, bus.bits_reqlen},
          {e_up_ready, e_push, e_rdy, e_grant, (e_grant ? e_len : 4'd0)});
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_len, bus.rsp_data} !== {(p2_v ? 4'(1 << p2_id) : 4'd0), p2_len, p2_d}) begin
        errors++; $display("FAIL rand_rsp cycle %0d got %b/%0d/%h want %b/%0d/%h", i, bus.rsp_valid, bus.rsp_len, bus.rsp_data,
          (p2_v ? 4'(1 << p2_id) : 4'd0), p2_len, p2_d);
      end
      checks++;
      if ({bus.level, bus.err} !== {11'(m_level), m_err}) begin
        errors++; $display("FAIL rand_state cycle %0d got level=%0d err=%b want %0d %b", i, bus.level, bus.err, m_level, m_err);
      end
      advance();
    end
    bus.up_valid = 1'b0; bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_push_same_cycle();
    test_len_zero();
    test_fill();
    test_rr();
    test_no_bypass();
    test_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
